// File: rtl/cpu_pkg.sv
// Shared CPU constants and the writeback hold-slot entry type.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package cpu_pkg;

    localparam int DW   = 8;
    localparam int AW   = 4;
    localparam int NREG = 16;

    typedef struct packed {
        logic          v;
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } wb_entry_t;

    // One-hot register mask for a single held write, empty when v is low.
    function automatic logic [NREG-1:0] rd_mask(input logic v, input logic [AW-1:0] idx);
        rd_mask      = '0;
        rd_mask[idx] = v;
    endfunction

endpackage

// File: rtl/wb_hold_slot.sv
// One-entry holding register for a producer result awaiting register-file commit.
// Latency: result visible on v_o/rd_o/data_o the cycle after the accepting edge.
// Backpressure: ready_o low while full and not committing; never depends on valid_i.
module wb_hold_slot
    import cpu_pkg::*;
(
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          valid_i,
    input  logic [AW-1:0] rd_i,
    input  logic [DW-1:0] data_i,
    input  logic          commit_i,
    output logic          ready_o,
    output logic          load_o,
    output logic          v_o,
    output logic [AW-1:0] rd_o,
    output logic [DW-1:0] data_o
);

    wb_entry_t slot_q, slot_d;

    // Free when empty or draining this cycle; closed entirely during reset.
    assign ready_o = !rst_i && (!slot_q.v || commit_i);
    assign load_o  = valid_i && ready_o;

    // Next contents: a load wins over the drain so commit and refill share an edge.
    always_comb begin
        slot_d = slot_q;
        if (load_o) begin
            slot_d.v    = 1'b1;
            slot_d.rd   = rd_i;
            slot_d.data = data_i;
        end else if (commit_i) begin
            slot_d.v    = 1'b0;
        end
    end

    // Slot register; reset discards whatever was held.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign v_o    = slot_q.v;
    assign rd_o   = slot_q.rd;
    assign data_o = slot_q.data;

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: buffers one ALU and one LSU result, commits one RF write per cycle.
// Latency: 1 cycle accept-to-wrt_en, 2 when the other slot wins arbitration.
// Backpressure: per-producer ready drops only while its slot is full and not committing.
module wb_arbiter #(
    parameter int DW = cpu_pkg::DW,
    parameter int AW = cpu_pkg::AW,
    parameter int CW = 16
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               alu_valid,
    input  logic [AW-1:0]      alu_rd,
    input  logic [DW-1:0]      alu_data,
    output logic               alu_ready,
    input  logic               lsu_valid,
    input  logic [AW-1:0]      lsu_rd,
    input  logic [DW-1:0]      lsu_data,
    output logic               lsu_ready,
    output logic [AW-1:0]      reg_wrt,
    output logic [DW-1:0]      wrt_dat,
    output logic               wrt_en,
    output logic [(1<<AW)-1:0] pend_mask,
    output logic [CW-1:0]      commit_cnt,
    output logic [CW-1:0]      stall_cnt
);
    import cpu_pkg::*;

    // DW/AW must match cpu_pkg: the slot entries and the RF share those widths.
    wb_entry_t     alu_s, lsu_s;
    logic          alu_load, lsu_load, alu_commit, lsu_commit;
    logic          alu_older_q, alu_older_d;
    logic          last_lsu_q, last_lsu_d;
    logic [AW-1:0] last_rd_q;
    logic [DW-1:0] last_dat_q;
    logic [CW-1:0] commit_cnt_q, commit_cnt_d, stall_cnt_q, stall_cnt_d;
    logic          stall;

    wb_hold_slot u_alu_slot (
        .clk_i(CLK), .rst_i(RST),
        .valid_i(alu_valid), .rd_i(alu_rd), .data_i(alu_data),
        .commit_i(alu_commit), .ready_o(alu_ready), .load_o(alu_load),
        .v_o(alu_s.v), .rd_o(alu_s.rd), .data_o(alu_s.data)
    );

    wb_hold_slot u_lsu_slot (
        .clk_i(CLK), .rst_i(RST),
        .valid_i(lsu_valid), .rd_i(lsu_rd), .data_i(lsu_data),
        .commit_i(lsu_commit), .ready_o(lsu_ready), .load_o(lsu_load),
        .v_o(lsu_s.v), .rd_o(lsu_s.rd), .data_o(lsu_s.data)
    );

    // Grant at most one slot from held state; same-rd keeps program order, otherwise
    // round-robin, whose pointer moves only when both slots contend for different rds.
    // Nothing commits during reset so dropped results never reach the RF.
    always_comb begin
        alu_commit = 1'b0;
        lsu_commit = 1'b0;
        last_lsu_d = last_lsu_q;
        if (!RST) begin
            if (alu_s.v && lsu_s.v) begin
                if (alu_s.rd == lsu_s.rd) begin
                    alu_commit = alu_older_q;
                    lsu_commit = !alu_older_q;
                end else begin
                    alu_commit = last_lsu_q;
                    lsu_commit = !last_lsu_q;
                    last_lsu_d = !last_lsu_q;
                end
            end else begin
                alu_commit = alu_s.v;
                lsu_commit = lsu_s.v;
            end
        end
    end

    assign wrt_en  = alu_commit || lsu_commit;
    assign reg_wrt = lsu_commit ? lsu_s.rd   : (alu_commit ? alu_s.rd   : last_rd_q);
    assign wrt_dat = lsu_commit ? lsu_s.data : (alu_commit ? alu_s.data : last_dat_q);

    // Age: a slot filled alone while the other stays held is the younger one;
    // a simultaneous fill counts the LSU as older; emptying a slot clears the flag.
    always_comb begin
        alu_older_d = alu_older_q;
        if (alu_load && lsu_load) begin
            alu_older_d = 1'b0;
        end else if (alu_load && lsu_s.v && !lsu_commit) begin
            alu_older_d = 1'b0;
        end else if (lsu_load && alu_s.v && !alu_commit) begin
            alu_older_d = 1'b1;
        end else if ((alu_commit && !alu_load) || (lsu_commit && !lsu_load)) begin
            alu_older_d = 1'b0;
        end
    end

    // Wrapping performance counters.
    always_comb begin
        stall        = (alu_valid && !alu_ready) || (lsu_valid && !lsu_ready);
        commit_cnt_d = commit_cnt_q + {{(CW-1){1'b0}}, wrt_en};
        stall_cnt_d  = stall_cnt_q  + {{(CW-1){1'b0}}, stall};
    end

    // Arbitration state, last driven write port values and counters.
    always_ff @(posedge CLK) begin
        if (RST) begin
            alu_older_q  <= 1'b0;
            last_lsu_q   <= 1'b0;
            last_rd_q    <= '0;
            last_dat_q   <= '0;
            commit_cnt_q <= '0;
            stall_cnt_q  <= '0;
        end else begin
            alu_older_q  <= alu_older_d;
            last_lsu_q   <= last_lsu_d;
            last_rd_q    <= reg_wrt;
            last_dat_q   <= wrt_dat;
            commit_cnt_q <= commit_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign pend_mask  = rd_mask(alu_s.v, alu_s.rd) | rd_mask(lsu_s.v, lsu_s.rd);
    assign commit_cnt = commit_cnt_q;
    assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Randomized scoreboard bench for wb_arbiter against a timestamp-based reference model.
// Latency: model predicts each cycle's commit; monitor compares at the falling edge.
// Backpressure: producers drive freshly every cycle; only valid&&ready transfers count.
module tb_wb_arbiter;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       alu_valid = 1'b0, lsu_valid = 1'b0;
    logic [3:0] alu_rd = '0, lsu_rd = '0;
    logic [7:0] alu_data = '0, lsu_data = '0;

    logic        alu_ready, lsu_ready, wrt_en;
    logic [3:0]  reg_wrt;
    logic [7:0]  wrt_dat;
    logic [15:0] pend_mask, commit_cnt, stall_cnt;

    logic        d4_alu_ready, d4_lsu_ready, d4_wrt_en;
    logic [3:0]  d4_reg_wrt;
    logic [7:0]  d4_wrt_dat;
    logic [15:0] d4_pend_mask;
    logic [3:0]  d4_commit_cnt, d4_stall_cnt;

    wb_arbiter u_dut (
        .CLK(CLK), .RST(RST),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
        .reg_wrt(reg_wrt), .wrt_dat(wrt_dat), .wrt_en(wrt_en), .pend_mask(pend_mask),
        .commit_cnt(commit_cnt), .stall_cnt(stall_cnt)
    );

    // Narrow-counter instance sharing the same stimulus, for wrap checking.
    wb_arbiter #(.CW(4)) u_dut4 (
        .CLK(CLK), .RST(RST),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(d4_alu_ready),
        .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(d4_lsu_ready),
        .reg_wrt(d4_reg_wrt), .wrt_dat(d4_wrt_dat), .wrt_en(d4_wrt_en), .pend_mask(d4_pend_mask),
        .commit_cnt(d4_commit_cnt), .stall_cnt(d4_stall_cnt)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [3:0] rd;
        logic [7:0] data;
    } exp_t;
    exp_t exp_q[$];

    // Reference model: each held result carries the cycle it arrived in.
    bit         started = 0;
    int         cyc = 0;
    bit         m_av, m_lv, m_last_lsu;
    logic [3:0] m_ard, m_lrd, m_last_rd;
    logic [7:0] m_adat, m_ldat, m_last_dat;
    int         m_astamp, m_lstamp, m_ccnt, m_scnt;
    bit         d_galu, d_glsu, d_rr, d_arok, d_lrok, d_stall;
    logic [7:0] m_rf [16];
    logic [7:0] dut_rf [16];
    logic [15:0] m_pend;

    always begin : model
        @(posedge CLK);
        cyc++;
        if (RST) begin
            started    = 1;
            m_av       = 0;  m_lv = 0;  m_last_lsu = 0;
            m_ccnt     = 0;  m_scnt = 0;
            m_last_rd  = '0; m_last_dat = '0;
        end else if (started) begin
            if (d_galu) begin
                m_rf[m_ard] = m_adat; m_last_rd = m_ard; m_last_dat = m_adat; m_ccnt++; m_av = 0;
            end
            if (d_glsu) begin
                m_rf[m_lrd] = m_ldat; m_last_rd = m_lrd; m_last_dat = m_ldat; m_ccnt++; m_lv = 0;
            end
            if (d_rr) m_last_lsu = d_glsu;
            if (d_stall) m_scnt++;
            if (alu_valid && d_arok) begin
                m_av = 1; m_ard = alu_rd; m_adat = alu_data; m_astamp = cyc;
            end
            if (lsu_valid && d_lrok) begin
                m_lv = 1; m_lrd = lsu_rd; m_ldat = lsu_data; m_lstamp = cyc;
            end
        end
        #2;
        // Decide this cycle's commit from the rules: oldest first on same rd
        // (LSU wins a tie), alternate otherwise.
        d_galu = 0; d_glsu = 0; d_rr = 0;
        if (!RST) begin
            if (m_av && m_lv) begin
                if (m_ard == m_lrd) begin
                    if (m_astamp < m_lstamp) d_galu = 1; else d_glsu = 1;
                end else begin
                    d_rr = 1;
                    if (m_last_lsu) d_galu = 1; else d_glsu = 1;
                end
            end else if (m_av) begin
                d_galu = 1;
            end else if (m_lv) begin
                d_glsu = 1;
            end
        end
        d_arok  = !RST && (!m_av || d_galu);
        d_lrok  = !RST && (!m_lv || d_glsu);
        d_stall = (alu_valid && !d_arok) || (lsu_valid && !d_lrok);
        m_pend  = '0;
        if (m_av) m_pend[m_ard] = 1'b1;
        if (m_lv) m_pend[m_lrd] = 1'b1;
        if (started && d_galu) exp_q.push_back('{rd: m_ard, data: m_adat});
        if (started && d_glsu) exp_q.push_back('{rd: m_lrd, data: m_ldat});
    end

    // Monitor: pops the scoreboard on every RF write and checks the visible state.
    always @(negedge CLK) begin
        if (started) begin
            exp_t e;
            chk("wrt_en", {31'd0, wrt_en}, {31'd0, exp_q.size() > 0});
            if (wrt_en === 1'b1) dut_rf[reg_wrt] = wrt_dat;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (wrt_en === 1'b1) begin
                    chk("reg_wrt", {28'd0, reg_wrt}, {28'd0, e.rd});
                    chk("wrt_dat", {24'd0, wrt_dat}, {24'd0, e.data});
                end
            end else begin
                chk("reg_wrt_hold", {28'd0, reg_wrt}, {28'd0, m_last_rd});
                chk("wrt_dat_hold", {24'd0, wrt_dat}, {24'd0, m_last_dat});
            end
            chk("alu_ready", {31'd0, alu_ready}, {31'd0, d_arok});
            chk("lsu_ready", {31'd0, lsu_ready}, {31'd0, d_lrok});
            chk("pend_mask", {16'd0, pend_mask}, {16'd0, m_pend});
            chk("commit_cnt", {16'd0, commit_cnt}, m_ccnt & 32'hFFFF);
            chk("stall_cnt", {16'd0, stall_cnt}, m_scnt & 32'hFFFF);
            chk("commit_cnt_cw4", {28'd0, d4_commit_cnt}, m_ccnt & 32'hF);
        end
    end

    task automatic drive(input bit rst, input bit av, input logic [3:0] ard, input logic [7:0] adat,
                         input bit lv, input logic [3:0] lrd, input logic [7:0] ldat);
        @(posedge CLK);
        #1;
        RST = rst;
        alu_valid = av; alu_rd = ard; alu_data = adat;
        lsu_valid = lv; lsu_rd = lrd; lsu_data = ldat;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 4'd0, 8'd0, 0, 4'd0, 8'd0);
    endtask

    initial begin
        for (int r = 0; r < 16; r++) begin
            m_rf[r] = 8'h00;
            dut_rf[r] = 8'h00;
        end
        drive(1, 0, 4'd0, 8'd0, 0, 4'd0, 8'd0);
        idle(2);
        // Single ALU write.
        drive(0, 1, 4'd3, 8'h5A, 0, 4'd0, 8'd0);
        idle(2);
        // Contended, different rd; ALU held through its one blocked cycle.
        drive(0, 1, 4'd2, 8'h11, 1, 4'd9, 8'h22);
        drive(0, 1, 4'd2, 8'h11, 0, 4'd0, 8'd0);
        idle(3);
        // Same-rd ordering: LSU rd5 blocked by an ALU win, then ALU rd5 arrives.
        drive(0, 1, 4'd7, 8'h01, 1, 4'd5, 8'hAA);
        drive(0, 1, 4'd5, 8'hBB, 0, 4'd0, 8'd0);
        idle(3);
        // Back-to-back streaming.
        for (int i = 0; i < 16; i++) drive(0, 1, 4'(i), 8'(i + 1), 0, 4'd0, 8'd0);
        idle(2);
        // Reset with both slots full.
        drive(0, 1, 4'd1, 8'h33, 1, 4'd2, 8'h44);
        drive(1, 0, 4'd0, 8'd0, 0, 4'd0, 8'd0);
        idle(2);
        // Random traffic, narrow rd range half the time to provoke same-rd hazards.
        for (int i = 0; i < 3000; i++) begin
            bit narrow;
            narrow = ($urandom % 2) == 0;
            drive(($urandom % 120) == 0,
                  ($urandom % 10) < 7, narrow ? 4'($urandom % 3) : 4'($urandom), 8'($urandom),
                  ($urandom % 10) < 6, narrow ? 4'($urandom % 3) : 4'($urandom), 8'($urandom));
        end
        idle(4);
        chk("scoreboard_drained", exp_q.size(), 0);
        for (int r = 0; r < 16; r++) chk("rf_contents", {24'd0, dut_rf[r]}, {24'd0, m_rf[r]});
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
